// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the serial subtractor.
//   state_e  : FSM encoding {IDLE, RUN, DONE}
//   cnt_w()  : slice-counter width for a given slice count (min 1 bit)
//   DEF_*    : default geometry (32-bit operands, 4-bit slices)
package sub_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CHUNK  = 4;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_CHUNK;

  // A single-slice build still needs a 1-bit counter to stay legal.
  function automatic int cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_chunk.sv
// sub_chunk: combinational CHUNK-bit ripple subtractor (full-subtractor cells).
//   a, b  : slice operands (computes a - b)
//   bin   : borrow into bit 0
//   d     : slice difference
//   bout  : borrow out of the top bit
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int i = 0; i < CHUNK; i++) begin
      d[i]    = a[i] ^ b[i] ^ br[i];
      // borrow when a<b, or a==b and a borrow is already pending
      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[CHUNK];
  end

endmodule

// File: rtl/sub_serial.sv
// sub_serial: multi-cycle serial subtractor, diff = d0 - d1, CHUNK bits/cycle.
//   clk, rst_n         : clock, async active-low reset
//   start / ready      : request handshake (accepted when ready=1)
//   d0, d1             : operands, sampled on the accepting edge
//   done               : one-cycle pulse when results become valid
//   diff, borrow_out,
//   overflow           : registered results, held until the next done
//   zero, negative     : extra result flags, present only when the
//                        SUB_SERIAL_FLAGS_EN macro is defined
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SUB_SERIAL_FLAGS_EN
  output logic             overflow,
  output logic             zero,
  output logic             negative
`else
  output logic             overflow
`endif
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NSLICE);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("sub_serial: CHUNK must divide WIDTH");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  sh_q, sh_d;     // diff shadow, filled slice by slice
  logic              bor_q;
  logic [CW-1:0]     cnt_q;
  logic              ready_q, done_q, bo_q, ov_q;
  logic [WIDTH-1:0]  diff_q;

  logic [CHUNK-1:0]  a_sl, b_sl, d_sl;
  logic              bout;

  // Slice mux / demux by compare rather than a multiplied part-select index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    sh_d = sh_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl                 = a_q[i*CHUNK +: CHUNK];
        b_sl                 = b_q[i*CHUNK +: CHUNK];
        sh_d[i*CHUNK +: CHUNK] = d_sl;
      end
    end
  end

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (bor_q),
    .d    (d_sl),
    .bout (bout)
  );

`ifdef SUB_SERIAL_FLAGS_EN
  logic zero_q, neg_q;
  assign zero     = zero_q;
  assign negative = neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SUB_SERIAL_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= d0;
            b_q     <= d1;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        RUN: begin
          sh_q  <= sh_d;
          bor_q <= bout;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(NSLICE-1)) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            diff_q  <= sh_d;
            bo_q    <= bout;
            ov_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                       (sh_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SUB_SERIAL_FLAGS_EN
            zero_q  <= (sh_d == '0);
            neg_q   <= sh_d[WIDTH-1];
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule
